acc_iq_avg_capture_ctrl: RTL



---
 rtl/acc_iq_avg_pkg.sv | 21 ++
 rtl/acc_iq_avg_capture_ctrl_if.sv | 13 +
 rtl/acc_iq_avg_addr_gen.sv | 16 +
 rtl/acc_iq_avg_capture_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/acc_iq_avg_pkg.sv
// acc_iq_avg_pkg: shared states, register bit positions and status packing for the IQ averaging capture
package acc_iq_avg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SYNC = 2'd1, ACCUM = 2'd2, DONE = 2'd3} state_t;
  localparam int ST_STATE_LO = 0;
  localparam int ST_STATE_HI = 1;
  localparam int ST_DONE = 2;
  localparam int ST_SYNC_ERR = 3;
  localparam int ST_CNT_LO = 16;
  localparam int CTRL_ARM = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_NAVG_LO = 16;
  function automatic logic [31:0] pack_status(state_t s, logic done, logic sync_err, logic [15:0] cnt);
    logic [31:0] r;
    r = '0;
    r[ST_STATE_HI:ST_STATE_LO] = s;
    r[ST_DONE] = done;
    r[ST_SYNC_ERR] = sync_err;
    r[ST_CNT_LO +: 16] = cnt;
    return r;
  endfunction
endpackage

// File: rtl/acc_iq_avg_capture_ctrl_if.sv
// acc_iq_avg_capture_ctrl_if: control, sample strobes and accumulator/BRAM drive of the capture controller
interface acc_iq_avg_capture_ctrl_if #(parameter int ADDR_W = 9);
  logic [31:0] ctrl_in;
  logic sync_in;
  logic valid_in;
  logic acc_en;
  logic acc_first;
  logic bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0] status_out;
  modport master (output ctrl_in, sync_in, valid_in, input acc_en, acc_first, bram_we, bram_addr, status_out);
  modport slave (input ctrl_in, sync_in, valid_in, output acc_en, acc_first, bram_we, bram_addr, status_out);
endinterface

// File: rtl/acc_iq_avg_addr_gen.sv
// acc_iq_avg_addr_gen: frame address wrap counter with clear, increment and last-address flag
module acc_iq_avg_addr_gen #(parameter int ADDR_W = 9) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  always_comb addr_d = clr ? '0 : inc ? addr_q + ADDR_W'(1) : addr_q;
  always_ff @(posedge user_clk)
    addr_q <= !user_rst_n ? '0 : addr_d;
  assign addr = addr_q;
  assign last = &addr_q;
endmodule

// File: rtl/acc_iq_avg_capture_ctrl.sv
// acc_iq_avg_capture_ctrl: arms on software edge, waits for frame sync, drives n_avg frames of accumulate/BRAM writes
module acc_iq_avg_capture_ctrl
  import acc_iq_avg_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input logic user_clk,
  input logic user_rst_n,
  acc_iq_avg_capture_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, n_avg_q, n_avg_d, n_avg_raw;
  logic done_q, done_d, sync_err_q, sync_err_d, arm_q;
  logic acc_en_q, acc_en_d, acc_first_q, acc_first_d, bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d, addr;
  logic [31:0] status_q, status_d;
  logic last, accept, clr, arm_rise, abort, sync_valid;
  wire ctrl_unused = ^bus.ctrl_in[CTRL_NAVG_LO-1:CTRL_ABORT+1];
  assign arm_rise = bus.ctrl_in[CTRL_ARM] & ~arm_q;
  assign abort = bus.ctrl_in[CTRL_ABORT];
  assign sync_valid = bus.sync_in & bus.valid_in;
  assign n_avg_raw = bus.ctrl_in[CTRL_NAVG_LO +: CNT_W];
  acc_iq_avg_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .clr(clr), .inc(accept), .addr(addr), .last(last)
  );
  always_comb begin
    state_d = state_q;
    frame_cnt_d = frame_cnt_q;
    n_avg_d = n_avg_q;
    done_d = done_q;
    sync_err_d = sync_err_q;
    accept = 1'b0;
    clr = 1'b0;
    if (abort) begin
      state_d = IDLE;
      clr = 1'b1;
    end else if ((state_q == IDLE || state_q == DONE) && arm_rise) begin
      state_d = WAIT_SYNC;
      frame_cnt_d = '0;
      done_d = 1'b0;
      sync_err_d = 1'b0;
      n_avg_d = n_avg_raw == '0 ? CNT_W'(1) : n_avg_raw;
      clr = 1'b1;
    end else if (state_q == WAIT_SYNC && sync_valid) begin
      state_d = ACCUM;
      accept = 1'b1;
    end else if (state_q == ACCUM && sync_valid && addr != '0) begin
      // a sync inside a frame means lost alignment: drop the sample and stop
      state_d = IDLE;
      sync_err_d = 1'b1;
      clr = 1'b1;
    end else if (state_q == ACCUM && bus.valid_in) begin
      accept = 1'b1;
      if (last) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        if (frame_cnt_d == n_avg_q) begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
    end
    acc_en_d = accept;
    bram_we_d = accept;
    acc_first_d = accept && frame_cnt_q == '0;
    bram_addr_d = addr;
    status_d = pack_status(state_d, done_d, sync_err_d, 16'(frame_cnt_d));
  end
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      frame_cnt_q <= '0;
      n_avg_q <= '0;
      done_q <= 1'b0;
      sync_err_q <= 1'b0;
      arm_q <= 1'b0;
      acc_en_q <= 1'b0;
      acc_first_q <= 1'b0;
      bram_we_q <= 1'b0;
      bram_addr_q <= '0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      frame_cnt_q <= frame_cnt_d;
      n_avg_q <= n_avg_d;
      done_q <= done_d;
      sync_err_q <= sync_err_d;
      arm_q <= bus.ctrl_in[CTRL_ARM];
      acc_en_q <= acc_en_d;
      acc_first_q <= acc_first_d;
      bram_we_q <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      status_q <= status_d;
    end
  end
  assign bus.acc_en = acc_en_q;
  assign bus.acc_first = acc_first_q;
  assign bus.bram_we = bram_we_q;
  assign bus.bram_addr = bram_addr_q;
  assign bus.status_out = status_q;
endmodule
